// File: rtl/pc_lut_pkg.sv
// ---------------------------------------------------------------------------
// pc_lut_pkg
// Shared sizing, types and FSM encoding for the branch-target table.
//   PC_LUT_DEPTH / PC_LUT_AW / PC_LUT_DW : table depth, index width, target width
//   pc_idx_t / pc_tgt_t                  : index and target value types
//   pc_wr_state_t                        : loader FSM states
// ---------------------------------------------------------------------------
package pc_lut_pkg;

    localparam int PC_LUT_DEPTH = 32;
    localparam int PC_LUT_AW    = 5;
    localparam int PC_LUT_DW    = 8;

    typedef logic [PC_LUT_AW-1:0] pc_idx_t;
    typedef logic [PC_LUT_DW-1:0] pc_tgt_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } pc_wr_state_t;

endpackage : pc_lut_pkg

// File: rtl/pc_target_writer_if.sv
// ---------------------------------------------------------------------------
// pc_target_writer_if
// Valid/ready stream carrying branch targets from the program loader.
//   in_valid : loader has a target beat
//   in_data  : target value for the entry at the current load pointer
//   in_ready : table writer accepts a beat this cycle
// Modports: master = program loader, slave = pc_target_writer.
// ---------------------------------------------------------------------------
interface pc_target_writer_if
    import pc_lut_pkg::*;
#(
    parameter int DW = PC_LUT_DW
);

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface : pc_target_writer_if

// File: rtl/pc_target_ram.sv
// ---------------------------------------------------------------------------
// pc_target_ram
// DEPTH x DW register table: one synchronous write port, one combinational
// read port, synchronous clear on Reset.
//   Clk, Reset          : clock, synchronous active-high clear of all entries
//   we, waddr, wdata    : write port (captured on rising Clk)
//   raddr, rdata        : combinational read; indices >= DEPTH read as 0
// ---------------------------------------------------------------------------
module pc_target_ram
    import pc_lut_pkg::*;
#(
    parameter int DEPTH = PC_LUT_DEPTH,
    parameter int AW    = PC_LUT_AW,
    parameter int DW    = PC_LUT_DW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // NOTE: the table is register-based and consumers may read it before the
    // first load, so every entry is cleared on reset rather than left unknown.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Only a partially populated index space needs the out-of-range guard.
    if (DEPTH < (1 << AW)) begin : g_partial
        assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;
    end else begin : g_full
        assign rdata = mem_q[raddr];
    end

endmodule : pc_target_ram

// File: rtl/pc_target_writer.sv
// ---------------------------------------------------------------------------
// pc_target_writer
// Loads the branch-target table from the loader stream and serves the
// combinational index -> target read used by fetch.
//   Clk, Reset  : clock, synchronous active-high reset
//   load_start  : pulse, begins or restarts a full-table load at index 0
//   in_if       : target stream (slave side of pc_target_writer_if)
//   load_ptr    : index the next accepted beat writes
//   load_done   : one-cycle pulse after the final beat is accepted
//   loaded      : table holds a complete image
//   index/value : combinational table read
// Build option: PC_TARGET_WR_BYPASS_EN forwards an in-flight beat to value
// when index matches load_ptr in the same cycle.
// ---------------------------------------------------------------------------
module pc_target_writer
    import pc_lut_pkg::*;
#(
    parameter int DEPTH = PC_LUT_DEPTH,
    parameter int AW    = PC_LUT_AW,
    parameter int DW    = PC_LUT_DW
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                load_start,
    pc_target_writer_if.slave   in_if,
    output logic [AW-1:0]       load_ptr,
    output logic                load_done,
    output logic                loaded,
    input  logic [AW-1:0]       index,
    output logic [DW-1:0]       value
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    pc_wr_state_t  state_q,     state_d;
    logic [AW-1:0] load_ptr_q,  load_ptr_d;
    logic          loaded_q,    loaded_d;
    logic          load_done_q, load_done_d;
    logic          in_ready_q,  in_ready_d;
    logic          we;
    logic [DW-1:0] ram_rdata;

    // NOTE: every signal assigned here gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        load_ptr_d  = load_ptr_q;
        loaded_d    = loaded_q;
        load_done_d = 1'b0;
        we          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d    = LOAD;
                    load_ptr_d = '0;
                    loaded_d   = 1'b0;
                end
            end
            LOAD: begin
                // A restart wins over a coincident beat; that beat is dropped.
                if (load_start) begin
                    load_ptr_d = '0;
                end else if (in_if.in_valid) begin
                    we = 1'b1;
                    if (load_ptr_q == LAST_IDX) begin
                        state_d     = IDLE;
                        load_ptr_d  = '0;
                        loaded_d    = 1'b1;
                        load_done_d = 1'b1;
                    end else begin
                        load_ptr_d = load_ptr_q + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Ready is a pure function of the next state, so it is a flop with
        // no combinational path from in_valid.
        in_ready_d = (state_d == LOAD);
    end

    // NOTE: state flops use non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            load_ptr_q  <= '0;
            loaded_q    <= 1'b0;
            load_done_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_ptr_q  <= load_ptr_d;
            loaded_q    <= loaded_d;
            load_done_q <= load_done_d;
            in_ready_q  <= in_ready_d;
        end
    end

    pc_target_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .Clk   (Clk),
        .Reset (Reset),
        .we    (we),
        .waddr (load_ptr_q),
        .wdata (in_if.in_data),
        .raddr (index),
        .rdata (ram_rdata)
    );

    assign in_if.in_ready = in_ready_q;
    assign load_ptr       = load_ptr_q;
    assign load_done      = load_done_q;
    assign loaded         = loaded_q;

`ifdef PC_TARGET_WR_BYPASS_EN
    assign value = (we && (index == load_ptr_q)) ? in_if.in_data : ram_rdata;
`else
    assign value = ram_rdata;
`endif

endmodule : pc_target_writer

// File: doc/pc_target_writer.md
# pc_target_writer

Programmable branch-target table: the write side of the PC lookup path. Branch instructions carry a 5-bit target index that is resolved to an 8-bit program-counter target. This block loads those targets at boot from an 8-bit valid/ready stream, fed by the program loader, into a 32-entry register table. It serves the same combinational index→value read that the fetch stage consumes.

## Interface
Parameters:
- DEPTH, 32, number of table entries
- AW, 5, index width (log2 DEPTH)
- DW, 8, target width

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- load_start  in  1  one-cycle pulse; begins (or restarts) a full-table load at index 0
- in_valid  in  1  stream data valid
- in_data  in  DW  target value for the entry at load_ptr
- in_ready  out  1  block accepts a beat this cycle
- load_ptr  out  AW  index that the next accepted beat writes
- load_done  out  1  one-cycle pulse; full table written
- loaded  out  1  table holds a complete, valid image
- index  in  AW  read index from fetch/branch logic
- value  out  DW  combinational target for index

## Operation
- Clock and reset: one clock, Clk. Reset is synchronous and active-high, named Reset.
- FSM states: IDLE and LOAD.
- IDLE → LOAD on load_start. load_ptr is set to 0 and loaded is cleared.
- In LOAD:
  - in_ready = 1.
  - A beat is accepted when in_valid && in_ready. It writes table[load_ptr] = in_data and increments load_ptr.
  - When the beat at load_ptr = DEPTH-1 is accepted, the FSM goes to IDLE, load_ptr wraps to 0, loaded is set to 1, and load_done is asserted for the next cycle.
- load_start while in LOAD restarts the load: load_ptr = 0 and loaded stays 0. A simultaneous in_valid beat is dropped, not written.
- in_valid while in IDLE is ignored: no write, in_ready = 0.
- Read: value = table[index], combinational, available in any state. Unloaded or stale entries read their current contents. Consumers gate their use of value on loaded.
- Index is full-range, so there is no out-of-range case. Any future DEPTH < 2^AW returns 0 for out-of-range indices.
- Reset (including mid-load):
  - all table entries = 0
  - state = IDLE, load_ptr = 0
  - loaded = 0, load_done = 0, in_ready = 0

## Timing
- Write latency: a beat accepted at edge N is visible on value from edge N onward. It is readable in cycle N+1 without bypass.
- Throughput: one beat per cycle. A full load takes DEPTH accepted beats, at minimum 32 cycles after the load_start edge.
- load_start is registered: in_ready rises in the cycle after the load_start edge.
- load_done and loaded both rise in the cycle after the final beat is accepted. load_done lasts exactly one cycle.
- in_ready depends only on state. It has no combinational path from in_valid.

## Configuration
- Macro: PC_TARGET_WR_BYPASS_EN.
- Defined: write-through bypass. When in_valid && in_ready && index == load_ptr in the same cycle, value = in_data combinationally.
- Undefined: value always reflects stored table contents. The new data appears on the cycle after the write.

## Structure
- Package pc_lut_pkg holds:
  - localparams PC_LUT_DEPTH = 32, PC_LUT_AW = 5, PC_LUT_DW = 8
  - typedef pc_idx_t = logic [AW-1:0], pc_tgt_t = logic [DW-1:0]
  - enum pc_wr_state_t {IDLE, LOAD}
- One sub-module, pc_target_ram:
  - DEPTH×DW register array with one synchronous write port (we, waddr, wdata) and one combinational read port
  - synchronous clear on Reset
- The top level holds the FSM, load_ptr counter, handshake and optional bypass mux.

## Test plan
- Reset then idle: after Reset, with index swept 0..31, value = 0 for every index; in_ready = 0, loaded = 0.
- Full load: load_start, then 32 back-to-back beats with in_data = 8'hA0 + i. Expect load_done for exactly one cycle, loaded = 1, and value(i) = 8'hA0 + i for every i.
- Backpressure gaps: the same load with in_valid toggled randomly. Expect load_ptr to advance only on accepted beats and final contents identical to the full-load case.
- Restart mid-load: load_start after 10 beats, with in_valid high in the same cycle. Expect that beat dropped, load_ptr = 0, and after 32 more beats table[i] holds the second stream.
- Reset mid-load: assert Reset after beat 20. Expect all entries 0, loaded = 0, state IDLE, and no load_done pulse.
- Bypass: index = 5 while beat 5 = 8'h47 is presented.
  - With PC_TARGET_WR_BYPASS_EN: value = 8'h47 in the same cycle.
  - Without it: old value in that cycle, 8'h47 the next cycle.
